jtdd_rom_sched: RTL and testbench

Four-slot SDRAM read scheduler for the JTDD core. It shares the single SDRAM read port (sdram_req / sdram_ack / data_rdy / data_read) between the main CPU, sound CPU, char and scroll ROM fetchers. Each slot has a one-entry 32-bit cache, and misses are granted round-robin. It sits between the per-slot ROM address generators in jtdd_game and the SDRAM controller, and it also drives refresh_en.

---
 rtl/jtdd_pkg.sv | 17 +
 rtl/jtdd_rr_pick.sv | 25 ++
 rtl/jtdd_rom_sched.sv | 124 ++++++++++++
 tb/tb_jtdd_rom_sched.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/jtdd_pkg.sv
// Shared types and constants for the JTDD SDRAM ROM read scheduler.
package jtdd_pkg;
    localparam int SLOTS = 4;
    localparam int AW    = 22;
    localparam int DW    = 32;

    localparam int MAIN = 0;
    localparam int SND  = 1;
    localparam int CHAR = 2;
    localparam int SCR  = 3;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_REQ,
        ST_WAIT
    } state_t;
endpackage

// File: rtl/jtdd_rr_pick.sv
// Combinational 4-way round-robin pick: first missing slot at or after the pointer.
module jtdd_rr_pick
    import jtdd_pkg::*;
(
    input  logic [SLOTS-1:0] i_miss,
    input  logic [1:0]       i_pointer,
    output logic [1:0]       o_grant,
    output logic             o_any
);
    logic [1:0] w_idx;

    // Scan from the farthest offset down so the nearest candidate wins last.
    always_comb begin
        o_grant = i_pointer;
        o_any   = 1'b0;
        w_idx   = '0;
        for (int i = SLOTS - 1; i >= 0; i--) begin
            w_idx = i_pointer + 2'(i);
            if (i_miss[w_idx]) begin
                o_grant = w_idx;
                o_any   = 1'b1;
            end
        end
    end
endmodule

// File: rtl/jtdd_rom_sched.sv
// Four-slot SDRAM read scheduler: one-word cache per slot, misses served round-robin.
module jtdd_rom_sched #(
    parameter int SLOTS = 4,
    parameter int AW    = 22
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [SLOTS-1:0]    slot_cs,
    input  logic [SLOTS*AW-1:0] slot_addr,
    output logic [SLOTS-1:0]    slot_ok,
    output logic [SLOTS*32-1:0] slot_dout,
    input  logic                downloading,
    input  logic                loop_rst,
    output logic                sdram_req,
    output logic [AW-1:0]       sdram_addr,
    input  logic                sdram_ack,
    input  logic                data_rdy,
    input  logic [31:0]         data_read,
    output logic                refresh_en
);
    import jtdd_pkg::*;

    state_t          r_state, w_state_nxt;
    logic [AW-1:0]   r_tag  [SLOTS];
    logic [DW-1:0]   r_data [SLOTS];
    logic [SLOTS-1:0] r_valid, r_ok;
    logic [1:0]      r_ptr, r_grant, w_pick;
    logic [AW-1:0]   r_issue_addr, w_pick_addr;
    logic            r_refresh;
    logic [SLOTS-1:0] w_hit, w_miss, w_inflight;
    logic            w_any, w_start, w_fill, w_clr;

    assign w_clr      = rst | loop_rst;
    assign slot_ok    = r_ok;
    assign sdram_addr = r_issue_addr;
    assign refresh_en = r_refresh;

    always_comb begin
        w_pick_addr = '0;
        for (int n = 0; n < SLOTS; n++) begin
            w_inflight[n] = (r_state != ST_IDLE) && (r_grant == 2'(n));
            w_hit[n]      = slot_cs[n] & r_valid[n] & (r_tag[n] == slot_addr[n*AW +: AW]);
            w_miss[n]     = slot_cs[n] & ~w_hit[n] & ~w_inflight[n];
            slot_dout[n*DW +: DW] = r_data[n];
            if (w_pick == 2'(n))
                w_pick_addr = slot_addr[n*AW +: AW];
        end
    end

    jtdd_rr_pick u_pick (
        .i_miss    (w_miss),
        .i_pointer (r_ptr),
        .o_grant   (w_pick),
        .o_any     (w_any)
    );

    always_comb begin
        w_state_nxt = r_state;
        w_start     = 1'b0;
        w_fill      = 1'b0;
        sdram_req   = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_any && !downloading) begin
                    w_start     = 1'b1;
                    w_state_nxt = ST_REQ;
                end
            end
            ST_REQ: begin
                sdram_req = 1'b1;
                // Ack and data together: fill immediately and skip WAIT.
                if (sdram_ack) begin
                    if (data_rdy) begin
                        w_fill      = 1'b1;
                        w_state_nxt = ST_IDLE;
                    end else begin
                        w_state_nxt = ST_WAIT;
                    end
                end
            end
            ST_WAIT: begin
                if (data_rdy) begin
                    w_fill      = 1'b1;
                    w_state_nxt = ST_IDLE;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (w_clr) begin
            r_state      <= ST_IDLE;
            r_ptr        <= '0;
            r_grant      <= '0;
            r_issue_addr <= '0;
            r_valid      <= '0;
            r_ok         <= '0;
            r_refresh    <= 1'b0;
            for (int n = 0; n < SLOTS; n++) begin
                r_tag[n]  <= '0;
                r_data[n] <= '0;
            end
        end else begin
            r_state   <= w_state_nxt;
            r_ok      <= downloading ? '0 : w_hit;
            r_refresh <= downloading | ((r_state == ST_IDLE) && !w_any);
            if (w_start) begin
                r_grant      <= w_pick;
                r_issue_addr <= w_pick_addr;
            end
            // Data lands under the issued tag even if the slot address moved on.
            if (w_fill) begin
                r_tag[r_grant]  <= r_issue_addr;
                r_data[r_grant] <= data_read;
                r_ptr           <= r_grant + 2'd1;
            end
            if (downloading)
                r_valid <= '0;
            else if (w_fill)
                r_valid[r_grant] <= 1'b1;
        end
    end
endmodule

// File: tb/tb_jtdd_rom_sched.sv
// Directed bench for jtdd_rom_sched with hand-computed expectations.
module tb_jtdd_rom_sched;
    localparam int AW = 22;

    logic          clk = 1'b0;
    logic          rst;
    logic [3:0]    slot_cs;
    logic [4*AW-1:0] slot_addr;
    logic [3:0]    slot_ok;
    logic [127:0]  slot_dout;
    logic          downloading;
    logic          loop_rst;
    logic          sdram_req;
    logic [AW-1:0] sdram_addr;
    logic          sdram_ack;
    logic          data_rdy;
    logic [31:0]   data_read;
    logic          refresh_en;

    int n_checks = 0;
    int n_errors = 0;

    always #10 clk = ~clk;

    jtdd_rom_sched #(.SLOTS(4), .AW(AW)) dut (
        .clk         (clk),
        .rst         (rst),
        .slot_cs     (slot_cs),
        .slot_addr   (slot_addr),
        .slot_ok     (slot_ok),
        .slot_dout   (slot_dout),
        .downloading (downloading),
        .loop_rst    (loop_rst),
        .sdram_req   (sdram_req),
        .sdram_addr  (sdram_addr),
        .sdram_ack   (sdram_ack),
        .data_rdy    (data_rdy),
        .data_read   (data_read),
        .refresh_en  (refresh_en)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_addr(input int s, input logic [AW-1:0] a);
        slot_addr[s*AW +: AW] = a;
    endtask

    function automatic logic [31:0] dout_of(input int s);
        return slot_dout[s*32 +: 32];
    endfunction

    function automatic logic [AW-1:0] fa(input int s, input int r);
        return (AW'(s) << 20) | AW'(r + 1);
    endfunction

    task automatic do_reset();
        rst = 1'b1;
        slot_cs = '0;
        slot_addr = '0;
        downloading = 1'b0;
        loop_rst = 1'b0;
        sdram_ack = 1'b0;
        data_rdy = 1'b0;
        data_read = '0;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic wait_req(input string tag);
        int n;
        n = 0;
        while (!sdram_req && n < 20) begin
            tick();
            n++;
        end
        chk(tag, 64'(sdram_req), 64'd1);
    endtask

    // Called in a REQ cycle: ack now, data on the following cycle.
    task automatic serve(input logic [31:0] d);
        sdram_ack = 1'b1;
        tick();
        sdram_ack = 1'b0;
        data_rdy = 1'b1;
        data_read = d;
        tick();
        data_rdy = 1'b0;
    endtask

    int cnt_req, cnt_ok, s, r;

    initial begin
        // Reset state
        do_reset();
        rst = 1'b1;
        tick();
        chk("rst_ok", 64'(slot_ok), 64'd0);
        chk("rst_req", 64'(sdram_req), 64'd0);
        chk("rst_addr", 64'(sdram_addr), 64'd0);
        chk("rst_refresh", 64'(refresh_en), 64'd0);
        chk("rst_dout", 64'(slot_dout[63:0] | slot_dout[127:64]), 64'd0);
        rst = 1'b0;
        tick();
        chk("idle_refresh", 64'(refresh_en), 64'd1);

        // Single miss on slot 2
        slot_cs[2] = 1'b1;
        set_addr(2, 22'h05_0010);
        tick();
        chk("miss_req", 64'(sdram_req), 64'd1);
        chk("miss_addr", 64'(sdram_addr), 64'h05_0010);
        chk("miss_refresh", 64'(refresh_en), 64'd0);
        tick();
        sdram_ack = 1'b1;
        tick();
        sdram_ack = 1'b0;
        chk("ack_drop", 64'(sdram_req), 64'd0);
        tick();
        tick();
        data_rdy = 1'b1;
        data_read = 32'hDEADBEEF;
        tick();
        data_rdy = 1'b0;
        chk("ok_not_yet", 64'(slot_ok[2]), 64'd0);
        tick();
        chk("ok_m2", 64'(slot_ok[2]), 64'd1);
        chk("dout2", 64'(dout_of(2)), 64'hDEADBEEF);

        // Hits for 100 cycles
        cnt_req = 0;
        cnt_ok = 0;
        for (int i = 0; i < 100; i++) begin
            tick();
            if (sdram_req) cnt_req++;
            if (!slot_ok[2]) cnt_ok++;
        end
        chk("hit_no_req", 64'(cnt_req), 64'd0);
        chk("hit_ok_lows", 64'(cnt_ok), 64'd0);
        chk("hit_refresh", 64'(refresh_en), 64'd1);

        // Fairness: all slots keep missing
        do_reset();
        for (int k = 0; k < 4; k++) set_addr(k, fa(k, 0));
        slot_cs = 4'hF;
        for (int k = 0; k < 8; k++) begin
            s = k % 4;
            r = k / 4;
            wait_req("fair_req");
            chk("fair_addr", 64'(sdram_addr), 64'(fa(s, r)));
            set_addr(s, fa(s, r + 1));
            serve(32'(k));
        end

        // Address change mid-fetch on slot 3
        do_reset();
        slot_cs = 4'b1000;
        set_addr(3, 22'h04_0000);
        wait_req("chg_req1");
        chk("chg_addr1", 64'(sdram_addr), 64'h04_0000);
        sdram_ack = 1'b1;
        tick();
        sdram_ack = 1'b0;
        set_addr(3, 22'h04_0001);
        data_rdy = 1'b1;
        data_read = 32'h1111_1111;
        tick();
        data_rdy = 1'b0;
        cnt_ok = 0;
        for (int i = 0; i < 20 && !sdram_req; i++) begin
            if (slot_ok[3]) cnt_ok++;
            tick();
        end
        chk("chg_stale_ok", 64'(cnt_ok), 64'd0);
        chk("chg_req2", 64'(sdram_req), 64'd1);
        chk("chg_addr2", 64'(sdram_addr), 64'h04_0001);
        serve(32'h2222_2222);
        tick();
        chk("chg_ok", 64'(slot_ok[3]), 64'd1);
        chk("chg_dout", 64'(dout_of(3)), 64'h2222_2222);

        // Download during WAIT
        do_reset();
        set_addr(0, 22'h01_0000);
        set_addr(1, 22'h02_0000);
        set_addr(2, 22'h03_0000);
        slot_cs = 4'b0111;
        wait_req("dl_req0");
        serve(32'hA0);
        wait_req("dl_req1");
        serve(32'hA1);
        wait_req("dl_req2");
        chk("dl_addr2", 64'(sdram_addr), 64'h03_0000);
        sdram_ack = 1'b1;
        tick();
        sdram_ack = 1'b0;
        downloading = 1'b1;
        tick();
        chk("dl_ok0", 64'(slot_ok), 64'd0);
        chk("dl_refresh", 64'(refresh_en), 64'd1);
        data_rdy = 1'b1;
        data_read = 32'hCAFE_F00D;
        tick();
        data_rdy = 1'b0;
        chk("dl_dout2", 64'(dout_of(2)), 64'hCAFE_F00D);
        cnt_req = 0;
        cnt_ok = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (sdram_req) cnt_req++;
            if (slot_ok != 4'b0) cnt_ok++;
        end
        chk("dl_no_req", 64'(cnt_req), 64'd0);
        chk("dl_no_ok", 64'(cnt_ok), 64'd0);
        downloading = 1'b0;
        wait_req("rf_req0");
        chk("rf_addr0", 64'(sdram_addr), 64'h01_0000);
        serve(32'hB0);
        wait_req("rf_req1");
        chk("rf_addr1", 64'(sdram_addr), 64'h02_0000);
        serve(32'hB1);
        wait_req("rf_req2");
        chk("rf_addr2", 64'(sdram_addr), 64'h03_0000);
        serve(32'hB2);
        tick();
        chk("rf_ok", 64'(slot_ok), 64'b0111);

        // Same-cycle ack and data in REQ
        do_reset();
        set_addr(0, 22'h00_1234);
        set_addr(1, 22'h00_5678);
        slot_cs = 4'b0011;
        wait_req("sc_req0");
        chk("sc_addr0", 64'(sdram_addr), 64'h00_1234);
        sdram_ack = 1'b1;
        data_rdy = 1'b1;
        data_read = 32'h5A5A_A5A5;
        tick();
        sdram_ack = 1'b0;
        data_rdy = 1'b0;
        chk("sc_idle", 64'(sdram_req), 64'd0);
        tick();
        chk("sc_req1", 64'(sdram_req), 64'd1);
        chk("sc_addr1", 64'(sdram_addr), 64'h00_5678);
        chk("sc_ok0", 64'(slot_ok[0]), 64'd1);
        chk("sc_dout0", 64'(dout_of(0)), 64'h5A5A_A5A5);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
